// File: rtl/top_pkg.sv
// rtl/top_pkg.sv - shared AXI encodings, bridge state enum and subsystem defaults
package top_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int SRAM_DEPTH_DEF = 1024;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_1B = 3'b000;
  localparam logic [2:0] SIZE_2B = 3'b001;
  localparam logic [2:0] SIZE_4B = 3'b010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RESP = 2'd2
  } bridge_state_e;

  function automatic logic [31:0] sram_init_word(input int unsigned idx);
    return 32'h1000_0000 + idx;
  endfunction

endpackage

// File: rtl/top_if.sv
// rtl/top_if.sv - AXI read path plus tied-off write handshakes between fake_cpu and the bridge
interface top_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [3:0]        arid;

  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic [3:0]        rid;

  logic              awvalid;
  logic              awready;
  logic              wvalid;
  logic              wready;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, arlen, arsize, arburst, arid, rready, awvalid, wvalid, bready,
    input  arready, rdata, rresp, rlast, rvalid, rid, awready, wready, bvalid
  );

  modport slave (
    input  araddr, arvalid, arlen, arsize, arburst, arid, rready, awvalid, wvalid, bready,
    output arready, rdata, rresp, rlast, rvalid, rid, awready, wready, bvalid
  );

endinterface

// File: rtl/axi_sram_bridge.sv
// rtl/axi_sram_bridge.sv - single-outstanding AXI read slave in front of a synchronous SRAM
module axi_sram_bridge
  import top_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int SRAM_DEPTH = SRAM_DEPTH_DEF,
  parameter int AW         = $clog2(SRAM_DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  top_if.slave          bus,
  output logic          sram_en,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  input  logic [31:0]   sram_dout
);

  bridge_state_e state;
  bridge_state_e state_nxt;
  logic [AW-1:0] word_addr;
  logic [3:0]    arid_q;
  logic [31:0]   rdata_q;
  logic          data_ok;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.arvalid && bus.arready) state_nxt = ST_RD;
      ST_RD:   state_nxt = ST_RESP;
      ST_RESP: if (bus.rvalid && bus.rready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // SRAM data lands during the first RESP cycle; it is registered there and rvalid follows.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      word_addr <= '0;
      arid_q    <= '0;
      rdata_q   <= '0;
      data_ok   <= 1'b0;
    end else begin
      if (state == ST_IDLE && bus.arvalid && bus.arready) begin
        word_addr <= bus.araddr[AW+1:2];
        arid_q    <= bus.arid;
      end
      if (state == ST_RESP && !data_ok) begin
        rdata_q <= sram_dout;
        data_ok <= 1'b1;
      end
      if (bus.rvalid && bus.rready) begin
        data_ok <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.arready = (state == ST_IDLE) && resetn;
    bus.rvalid  = (state == ST_RESP) && data_ok;
    bus.rdata   = rdata_q;
    bus.rresp   = RESP_OKAY;
    bus.rlast   = 1'b1;
    bus.rid     = arid_q;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    sram_en     = (state == ST_RD);
    sram_we     = 1'b0;
    sram_addr   = word_addr;
  end

  // Only single-beat 32-bit INCR reads arrive, so the burst descriptors carry no information here.
  logic unused_in;
  assign unused_in = ^{bus.araddr, bus.arlen, bus.arsize, bus.arburst,
                       bus.awvalid, bus.wvalid, bus.bready};

endmodule

// File: rtl/fake_cpu.sv
// rtl/fake_cpu.sv - idle AXI read master stub; its named nets are the handles benches override
module fake_cpu
  import top_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  top_if.master bus
);

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic        rready;
  logic [31:0] rdata;
  logic        axi_rd_ret;

  assign araddr  = '0;
  assign arvalid = 1'b0;
  assign rready  = 1'b1;

  assign arready    = bus.arready;
  assign rdata      = bus.rdata;
  assign axi_rd_ret = bus.rvalid & rready;

  assign bus.araddr  = ADDR_W'(araddr);
  assign bus.arvalid = arvalid;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = SIZE_4B;
  assign bus.arburst = BURST_INCR;
  assign bus.arid    = 4'd0;
  assign bus.rready  = rready;

  assign bus.awvalid = 1'b0;
  assign bus.wvalid  = 1'b0;
  assign bus.bready  = 1'b1;

  // Observation-only nets; nothing inside the stub consumes them.
  logic unused_obs;
  assign unused_obs = ^{arready, rdata, axi_rd_ret, bus.rresp, bus.rlast, bus.rid,
                        bus.awready, bus.wready, bus.bvalid};

endmodule

// File: rtl/sram_sp.sv
// rtl/sram_sp.sv - single-port synchronous SRAM, one-cycle read latency, preloaded image
module sram_sp
  import top_pkg::*;
#(
  parameter int DEPTH = SRAM_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  output logic [31:0]   dout
);

  logic [31:0] mem [DEPTH];

  // Each word carries its power-up image; reset never touches the array.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [31:0] word = sram_init_word(i);
    assign mem[i] = word;
  end

  always_ff @(posedge clk) begin
    if (en && !we) begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/top.sv
// rtl/top.sv - self-contained read subsystem: fake_cpu -> axi_sram_bridge -> sram_sp
module top
  import top_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int SRAM_DEPTH = SRAM_DEPTH_DEF
) (
  input logic clk,
  input logic resetn
);

  localparam int AW = $clog2(SRAM_DEPTH);

  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_dout;

  top_if #(.ADDR_W(ADDR_W)) bus ();

  fake_cpu #(.ADDR_W(ADDR_W)) fake_cpu (
    .bus (bus.master)
  );

  axi_sram_bridge #(
    .ADDR_W     (ADDR_W),
    .SRAM_DEPTH (SRAM_DEPTH),
    .AW         (AW)
  ) u_bridge (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus.slave),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_dout (sram_dout)
  );

  sram_sp #(
    .DEPTH (SRAM_DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (sram_we),
    .addr (sram_addr),
    .dout (sram_dout)
  );

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - directed bench for the read subsystem, driving fake_cpu nets hierarchically
module tb_top;
  import top_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  top dut (
    .clk    (clk),
    .resetn (resetn)
  );

  logic [31:0] cpu_araddr;
  logic        cpu_arvalid;
  logic        cpu_rready;
  int          npass = 0;
  int          nchk  = 0;
  int          nret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk = nchk + 1;
    assert (obs === exp) npass = npass + 1;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn      = 1'b0;
    cpu_araddr  = 32'h0;
    cpu_arvalid = 1'b0;
    cpu_rready  = 1'b1;
    force dut.fake_cpu.araddr  = cpu_araddr;
    force dut.fake_cpu.arvalid = cpu_arvalid;
    force dut.fake_cpu.rready  = cpu_rready;

    // reset
    repeat (3) tick();
    chk("rst_rvalid", 32'(dut.bus.rvalid), 32'd0);
    chk("rst_arready", 32'(dut.fake_cpu.arready), 32'd0);
    chk("rst_state", 32'(dut.u_bridge.state), 32'(ST_IDLE));
    resetn = 1'b1;
    tick();
    chk("post_rst_arready", 32'(dut.fake_cpu.arready), 32'd1);

    // single read with back-pressure
    cpu_araddr = 32'h0; cpu_arvalid = 1'b1; cpu_rready = 1'b0;
    #1;
    chk("rd0_arready_hs", 32'(dut.fake_cpu.arready), 32'd1);
    tick();
    cpu_arvalid = 1'b0;
    chk("rd0_rvalid_n1", 32'(dut.bus.rvalid), 32'd0);
    tick();
    chk("rd0_rvalid_n2", 32'(dut.bus.rvalid), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd0_hold_rvalid_%0d", i), 32'(dut.bus.rvalid), 32'd1);
      chk($sformatf("rd0_hold_rdata_%0d", i), dut.fake_cpu.rdata, 32'h1000_0000);
      chk($sformatf("rd0_hold_ret_%0d", i), 32'(dut.fake_cpu.axi_rd_ret), 32'd0);
      if (i < 3) tick();
    end
    cpu_rready = 1'b1;
    #1;
    chk("rd0_ret", 32'(dut.fake_cpu.axi_rd_ret), 32'd1);
    tick();
    chk("rd0_ret_after", 32'(dut.fake_cpu.axi_rd_ret), 32'd0);
    chk("rd0_arready_after", 32'(dut.fake_cpu.arready), 32'd1);

    // read with rready already high
    cpu_araddr = 32'h0000_0010; cpu_arvalid = 1'b1;
    tick();
    cpu_arvalid = 1'b0;
    tick();
    chk("rd4_ret_early", 32'(dut.fake_cpu.axi_rd_ret), 32'd0);
    tick();
    chk("rd4_ret", 32'(dut.fake_cpu.axi_rd_ret), 32'd1);
    chk("rd4_rdata", dut.fake_cpu.rdata, 32'h1000_0004);
    tick();
    chk("rd4_ret_after", 32'(dut.fake_cpu.axi_rd_ret), 32'd0);
    chk("rd4_arready_after", 32'(dut.fake_cpu.arready), 32'd1);

    // arvalid held through the first read: second request waits
    cpu_araddr = 32'h0000_0020; cpu_arvalid = 1'b1; cpu_rready = 1'b0;
    tick();
    cpu_araddr = 32'h0000_0030;
    chk("ovl_arready_rd", 32'(dut.fake_cpu.arready), 32'd0);
    tick();
    chk("ovl_arready_resp0", 32'(dut.fake_cpu.arready), 32'd0);
    tick();
    chk("ovl_rvalid", 32'(dut.bus.rvalid), 32'd1);
    chk("ovl_rdata1", dut.fake_cpu.rdata, 32'h1000_0008);
    chk("ovl_arready_resp1", 32'(dut.fake_cpu.arready), 32'd0);
    cpu_rready = 1'b1;
    #1;
    chk("ovl_ret1", 32'(dut.fake_cpu.axi_rd_ret), 32'd1);
    tick();
    chk("ovl_arready_idle", 32'(dut.fake_cpu.arready), 32'd1);
    tick();
    cpu_arvalid = 1'b0;
    tick();
    tick();
    chk("ovl_ret2", 32'(dut.fake_cpu.axi_rd_ret), 32'd1);
    chk("ovl_rdata2", dut.fake_cpu.rdata, 32'h1000_000C);
    tick();

    // address wrap beyond SRAM depth
    cpu_araddr = 32'(4 * SRAM_DEPTH_DEF + 8); cpu_arvalid = 1'b1;
    tick();
    cpu_arvalid = 1'b0;
    tick();
    tick();
    chk("wrap_rdata", dut.fake_cpu.rdata, 32'h1000_0002);
    chk("wrap_rresp", 32'(dut.bus.rresp), 32'(RESP_OKAY));
    chk("wrap_rlast", 32'(dut.bus.rlast), 32'd1);
    chk("wrap_ret", 32'(dut.fake_cpu.axi_rd_ret), 32'd1);
    tick();

    // reset during RESP aborts the beat
    cpu_araddr = 32'h0000_0040; cpu_arvalid = 1'b1; cpu_rready = 1'b0;
    tick();
    cpu_arvalid = 1'b0;
    tick();
    tick();
    chk("abort_rvalid_pre", 32'(dut.bus.rvalid), 32'd1);
    chk("abort_rdata_pre", dut.fake_cpu.rdata, 32'h1000_0010);
    resetn = 1'b0;
    tick();
    chk("abort_rvalid", 32'(dut.bus.rvalid), 32'd0);
    chk("abort_state", 32'(dut.u_bridge.state), 32'(ST_IDLE));
    chk("abort_arready", 32'(dut.fake_cpu.arready), 32'd0);
    resetn = 1'b1; cpu_rready = 1'b1;
    nret = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      nret = nret + int'(dut.fake_cpu.axi_rd_ret);
    end
    chk("abort_no_ret", 32'(nret), 32'd0);
    chk("abort_arready_after", 32'(dut.fake_cpu.arready), 32'd1);

    // SRAM contents survive reset
    cpu_araddr = 32'h0; cpu_arvalid = 1'b1;
    tick();
    cpu_arvalid = 1'b0;
    tick();
    tick();
    chk("keep_rdata", dut.fake_cpu.rdata, 32'h1000_0000);
    chk("keep_ret", 32'(dut.fake_cpu.axi_rd_ret), 32'd1);
    tick();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
